// File: rtl/fb_rect_fill.sv
// fb_rect_fill: clipped solid-rectangle filler for a linear framebuffer.
// Optional macro FB_CLEAR_ON_RESET_EN zeroes the whole framebuffer after reset.
module fb_rect_fill #(
    parameter int VGA_WIDTH       = 640,
    parameter int VGA_HEIGHT      = 480,
    parameter int VGA_COLOR_DEPTH = 4,
    parameter int BUFFER_WIDTH    = VGA_COLOR_DEPTH * 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [9:0]              cmd_x0_i,
    input  logic [9:0]              cmd_y0_i,
    input  logic [9:0]              cmd_x1_i,
    input  logic [9:0]              cmd_y1_i,
    input  logic [BUFFER_WIDTH-1:0] cmd_color_i,
    output logic                    wr_en_o,
    output logic [18:0]             wr_addr_o,
    output logic [BUFFER_WIDTH-1:0] wr_data_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [9:0]  XLIM = 10'(VGA_WIDTH - 1);
    localparam logic [9:0]  YLIM = 10'(VGA_HEIGHT - 1);
    localparam logic [18:0] ROW  = 19'(VGA_WIDTH);

`ifdef FB_CLEAR_ON_RESET_EN
    localparam logic [18:0] NPIX = 19'(VGA_WIDTH * VGA_HEIGHT);
    typedef enum logic [1:0] {IDLE, DRAW, DONE, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    state_t                  state_q;
    logic [9:0]              x_q, y_q;
    logic [9:0]              xmin_q, xmax_q, ymax_q;
    logic [18:0]             row_q;
    logic                    wr_en_q, done_q;
    logic [18:0]             addr_q;
    logic [BUFFER_WIDTH-1:0] data_q;
`ifdef FB_CLEAR_ON_RESET_EN
    logic [18:0]             clr_q;
`endif

    logic [9:0]  xmin_d, xmax_d, ymin_d, ymax_d, xhi, yhi;
    logic [18:0] base_d;
    logic        empty_d;

    // Normalise corners, clip the far edge and detect fully off-screen commands.
    always_comb begin
        xmin_d  = (cmd_x0_i < cmd_x1_i) ? cmd_x0_i : cmd_x1_i;
        xhi     = (cmd_x0_i < cmd_x1_i) ? cmd_x1_i : cmd_x0_i;
        ymin_d  = (cmd_y0_i < cmd_y1_i) ? cmd_y0_i : cmd_y1_i;
        yhi     = (cmd_y0_i < cmd_y1_i) ? cmd_y1_i : cmd_y0_i;
        xmax_d  = (xhi > XLIM) ? XLIM : xhi;
        ymax_d  = (yhi > YLIM) ? YLIM : yhi;
        empty_d = (xmin_d > XLIM) || (ymin_d > YLIM);
        // Once per command only; the per-pixel path uses adds.
        base_d  = 19'(ymin_d) * ROW;
    end

    // Control FSM with registered write port and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            x_q     <= '0;
            y_q     <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            row_q   <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef FB_CLEAR_ON_RESET_EN
            clr_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (cmd_valid_i) begin
                        xmin_q <= xmin_d;
                        xmax_q <= xmax_d;
                        ymax_q <= ymax_d;
                        data_q <= cmd_color_i;
                        if (empty_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAW;
                            wr_en_q <= 1'b1;
                            addr_q  <= base_d + 19'(xmin_d);
                            x_q     <= xmin_d;
                            y_q     <= ymin_d;
                            row_q   <= base_d;
                        end
                    end
                end
                DRAW: begin
                    if (x_q != xmax_q) begin
                        x_q    <= x_q + 10'd1;
                        addr_q <= row_q + 19'(x_q + 10'd1);
                    end else if (y_q != ymax_q) begin
                        x_q    <= xmin_q;
                        y_q    <= y_q + 10'd1;
                        row_q  <= row_q + ROW;
                        addr_q <= row_q + ROW + 19'(xmin_q);
                    end else begin
                        state_q <= DONE;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                end
`ifdef FB_CLEAR_ON_RESET_EN
                CLEAR: begin
                    if (clr_q == NPIX) begin
                        state_q <= DONE;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        wr_en_q <= 1'b1;
                        addr_q  <= clr_q;
                        data_q  <= '0;
                        clr_q   <= clr_q + 19'd1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = addr_q;
    assign wr_data_o   = data_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: scoreboard bench for fb_rect_fill.
// Expected writes/done pulses are queued by the driver and popped by a monitor.
module tb_fb_rect_fill;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int BW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [9:0]    cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i;
    logic [BW-1:0] cmd_color_i;
    logic          wr_en_o;
    logic [18:0]   wr_addr_o;
    logic [BW-1:0] wr_data_o;
    logic          busy_o;
    logic          done_o;

    fb_rect_fill #(
        .VGA_WIDTH(W),
        .VGA_HEIGHT(H),
        .VGA_COLOR_DEPTH(4),
        .BUFFER_WIDTH(BW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_x0_i(cmd_x0_i),
        .cmd_y0_i(cmd_y0_i),
        .cmd_x1_i(cmd_x1_i),
        .cmd_y1_i(cmd_y1_i),
        .cmd_color_i(cmd_color_i),
        .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t wq[$];
    int   dq[$];
    int   total = 0;
    int   bad = 0;
    bit   exp_ready = 1'b0;
    exp_t me;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Reference: every pixel of the clipped rectangle in raster order,
    // one per cycle starting with the handshake cycle, then done.
    task automatic push_model(int x0, int y0, int x1, int y1, int col, int hc);
        int xl, xh, yl, yh, n;
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        if (xh > W - 1) xh = W - 1;
        if (yh > H - 1) yh = H - 1;
        n = 0;
        if (xl < W && yl < H) begin
            for (int y = yl; y <= yh; y++) begin
                for (int x = xl; x <= xh; x++) begin
                    exp_t e;
                    e.addr = y * W + x;
                    e.data = col;
                    e.cyc  = hc + n;
                    wq.push_back(e);
                    n++;
                end
            end
        end
        dq.push_back(hc + n);
    endtask

    task automatic push_const(int addr, int col, int c);
        exp_t e;
        e.addr = addr;
        e.data = col;
        e.cyc  = c;
        wq.push_back(e);
    endtask

    // Monitor: pop and compare whenever the DUT writes or pulses done.
    always @(negedge clk) begin
        if (exp_ready) begin
            chk("ready_after_done", {31'd0, cmd_ready_o}, 32'd1);
            exp_ready = 1'b0;
        end
        if (wr_en_o === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(wr_addr_o), 32'hFFFF_FFFF);
            end else begin
                me = wq.pop_front();
                chk("wr_addr", 32'(wr_addr_o), 32'(me.addr));
                chk("wr_data", 32'(wr_data_o), 32'(me.data));
                chk("wr_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
        if (done_o === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
            end
            exp_ready = 1'b1;
        end
    end

    task automatic send(int x0, int y0, int x1, int y1, int col, output int hc);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("ready_timeout", 32'd0, 32'd1);
        cmd_x0_i    = 10'(x0);
        cmd_y0_i    = 10'(y0);
        cmd_x1_i    = 10'(x1);
        cmd_y1_i    = 10'(y1);
        cmd_color_i = BW'(col);
        cmd_valid_i = 1'b1;
        @(posedge clk);
        #1;
        hc = cyc;
    endtask

    // Keep valid high with garbage fields while busy; drop on done.
    task automatic scramble_until_done();
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                cmd_x0_i    = 10'($urandom);
                cmd_y0_i    = 10'($urandom);
                cmd_x1_i    = 10'($urandom);
                cmd_y1_i    = 10'($urandom);
                cmd_color_i = BW'($urandom);
                n++;
            end
        end
        cmd_valid_i = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int hc, x0, y0, x1, y1, col;
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_x0_i    = '0;
        cmd_y0_i    = '0;
        cmd_x1_i    = '0;
        cmd_y1_i    = '0;
        cmd_color_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_data", 32'(wr_data_o), 32'd0);
        rst_n = 1'b1;

        // Basic 3x2 fill with fixed addresses.
        send(2, 3, 4, 4, 'hABC, hc);
        push_const(1922, 'hABC, hc);
        push_const(1923, 'hABC, hc + 1);
        push_const(1924, 'hABC, hc + 2);
        push_const(2562, 'hABC, hc + 3);
        push_const(2563, 'hABC, hc + 4);
        push_const(2564, 'hABC, hc + 5);
        dq.push_back(hc + 6);
        chk("busy_in_draw", {31'd0, busy_o}, 32'd1);
        chk("ready_in_draw", {31'd0, cmd_ready_o}, 32'd0);
        scramble_until_done();

        // Swapped corners.
        send(4, 4, 2, 3, 'hABC, hc);
        push_const(1922, 'hABC, hc);
        push_const(1923, 'hABC, hc + 1);
        push_const(1924, 'hABC, hc + 2);
        push_const(2562, 'hABC, hc + 3);
        push_const(2563, 'hABC, hc + 4);
        push_const(2564, 'hABC, hc + 5);
        dq.push_back(hc + 6);
        scramble_until_done();

        // Bottom-right clipping.
        send(638, 479, 700, 500, 'h123, hc);
        push_const(307198, 'h123, hc);
        push_const(307199, 'h123, hc + 1);
        dq.push_back(hc + 2);
        scramble_until_done();

        // Fully off-screen: done next cycle, no writes.
        send(700, 0, 710, 5, 'h456, hc);
        dq.push_back(hc);
        scramble_until_done();

        // Randomized commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            x0  = $urandom_range(0, 719);
            y0  = $urandom_range(0, 519);
            x1  = x0 + $urandom_range(0, 24) - 12;
            y1  = y0 + $urandom_range(0, 24) - 12;
            if (x1 < 0) x1 = 0;
            if (y1 < 0) y1 = 0;
            if (i % 8 == 0) begin
                x1 = $urandom_range(1000, 1023);
            end
            col = $urandom_range(0, 4095);
            send(x0, y0, x1, y1, col, hc);
            push_model(x0, y0, x1, y1, col, hc);
            scramble_until_done();
        end

        // Reset during the 4th write of a 10x10 fill aborts it.
        send(0, 0, 9, 9, 'h777, hc);
        push_model(0, 0, 9, 9, 'h777, hc);
        while (wq.size() > 4) void'(wq.pop_back());
        void'(dq.pop_back());
        cmd_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_addr", 32'(wr_addr_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("abort_no_write", {31'd0, wr_en_o}, 32'd0);

        // Normal operation resumes after the abort.
        send(5, 1, 7, 2, 'h9F0, hc);
        push_model(5, 1, 7, 2, 'h9F0, hc);
        scramble_until_done();

        repeat (5) @(negedge clk);
        chk("writes_left", 32'(wq.size()), 32'd0);
        chk("dones_left", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
